// File: rtl/vALU_pkg.sv
// Shared vector-ALU definitions: vxrm rounding modes, SEW encodings and
// the per-element helpers used by the fixed-point rounding stage.
package vALU_pkg;

  typedef enum logic [1:0] {
    VXRM_RNU = 2'd0,
    VXRM_RNE = 2'd1,
    VXRM_RDN = 2'd2,
    VXRM_ROD = 2'd3
  } vxrm_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  // Rounding increment from the v[d] and v[d-1] bits of one element.
  function automatic logic round_inc(input vxrm_e vxrm, input logic vd, input logic vd1);
    logic inc;
    inc = 1'b0;
    case (vxrm)
      VXRM_RNU: inc = vd1;
      VXRM_RNE: inc = vd1 & vd;
      VXRM_RDN: inc = 1'b0;
      VXRM_ROD: inc = vd1 & ~vd;
      default:  inc = 1'b0;
    endcase
    return inc;
  endfunction

  // True when byte_idx is the low byte of an element at the given SEW.
  function automatic logic elem_lsb(input int byte_idx, input sew_e sew);
    return (byte_idx & ((32'sd1 <<< sew) - 32'sd1)) == 0;
  endfunction

endpackage

// File: rtl/vwb_fifo.sv
// Synchronous write-back FIFO: push and pop in the same cycle are both honoured,
// even when full; pushes into a full FIFO with no pop are dropped and flagged.
module vwb_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_almost_full,
  output logic                     o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_af;

  logic             w_do_pop;
  logic             w_do_push;
  logic [CW-1:0]    w_count_nxt;

  assign w_do_pop    = i_pop & (r_count != '0);
  assign w_do_push   = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);
  assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

  assign o_data        = r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_almost_full = r_af;
  assign o_drop        = i_push & ~w_do_push;

  // NOTE: storage has no reset; validity is tracked by the count, so clearing
  // the array would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_af     <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_af    <= (w_count_nxt >= CW'(AF_LEVEL));
    end
  end

endmodule

// File: rtl/vfxp_round_wb.sv
// Fixed-point rounding and write-back buffer: applies the vxrm increment to
// averaging-op results, registers the beat and queues it for the VRF write port.
module vfxp_round_wb
  import vALU_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_sew,
  input  logic [1:0]            cfg_vxrm,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_mask,
  input  logic                  in_fxp,
  input  logic [BE_WIDTH-1:0]   in_vd,
  input  logic [BE_WIDTH-1:0]   in_vd1,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [BE_WIDTH-1:0]   wb_be,
  output logic                  wb_mask,
  output logic                  almost_full,
  output logic                  err_overflow
);

  localparam int FW = DATA_WIDTH + ADDR_WIDTH + BE_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  w_round_en;
  logic [DATA_WIDTH-1:0] w_rnd_data;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BE_WIDTH-1:0]   r_be;
  logic                  r_mask;
  logic                  r_err;

  logic [FW-1:0]         w_head;
  logic [CW-1:0]         w_count;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_af;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [BE_WIDTH-1:0]   w_head_be;
  logic                  w_head_mask;

  assign w_round_en = in_fxp & ~in_mask;

  // Per-byte carry chain; the carry is replaced by the rounding increment at
  // each element's low byte, so nothing propagates across element boundaries.
  // NOTE: blocking assignments here model a ripple through one combinational
  // evaluation; the carry variable is assigned before every use, so no latch.
  always_comb begin
    logic w_carry;
    logic w_cin;
    w_rnd_data = '0;
    w_carry    = 1'b0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (elem_lsb(b, sew_e'(cfg_sew)))
        w_cin = w_round_en & round_inc(vxrm_e'(cfg_vxrm), in_vd[b], in_vd1[b]);
      else
        w_cin = w_carry;
      {w_carry, w_rnd_data[8*b +: 8]} = {1'b0, in_vec[8*b +: 8]} + 9'(w_cin);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_mask  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      r_data  <= in_valid ? w_rnd_data : '0;
      r_addr  <= in_valid ? in_addr    : '0;
      r_be    <= in_valid ? in_be      : '0;
      r_mask  <= in_valid & in_mask;
    end
  end

  assign w_pop = wb_valid & wb_ready;

  vwb_fifo #(
    .WIDTH    (FW),
    .DEPTH    (FIFO_DEPTH),
    .AF_LEVEL (FIFO_DEPTH - AF_THRESH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (r_valid),
    .i_data        ({r_data, r_addr, r_be, r_mask}),
    .i_pop         (w_pop),
    .o_data        (w_head),
    .o_count       (w_count),
    .o_almost_full (w_af),
    .o_drop        (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst)         r_err <= 1'b0;
    else if (w_drop) r_err <= 1'b1;
  end

  assign {w_head_data, w_head_addr, w_head_be, w_head_mask} = w_head;

  // Head fields are forced to zero while empty so stale storage never shows.
  assign wb_valid     = (w_count != '0);
  assign wb_data      = wb_valid ? w_head_data : '0;
  assign wb_addr      = wb_valid ? w_head_addr : '0;
  assign wb_be        = wb_valid ? w_head_be   : '0;
  assign wb_mask      = wb_valid & w_head_mask;
  assign almost_full  = w_af;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_vfxp_round_wb.sv
// Self-checking bench for vfxp_round_wb: directed rounding/backpressure steps
// plus randomized traffic against a queue-based reference model.
module tb_vfxp_round_wb;

  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int AFT   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cfg_sew, cfg_vxrm;
  logic          in_valid, in_mask, in_fxp;
  logic [DW-1:0] in_vec;
  logic [AW-1:0] in_addr;
  logic [BW-1:0] in_be, in_vd, in_vd1;
  logic          wb_valid, wb_ready, wb_mask, almost_full, err_overflow;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  logic [BW-1:0] wb_be;

  always #5 clk = ~clk;

  vfxp_round_wb #(
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .AF_THRESH  (AFT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_sew      (cfg_sew),
    .cfg_vxrm     (cfg_vxrm),
    .in_valid     (in_valid),
    .in_vec       (in_vec),
    .in_addr      (in_addr),
    .in_be        (in_be),
    .in_mask      (in_mask),
    .in_fxp       (in_fxp),
    .in_vd        (in_vd),
    .in_vd1       (in_vd1),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_addr      (wb_addr),
    .wb_be        (wb_be),
    .wb_mask      (wb_mask),
    .almost_full  (almost_full),
    .err_overflow (err_overflow)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic          mask;
  } beat_t;

  beat_t q[$];
  logic  st_v;
  beat_t st_b;
  logic  m_err;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element-wise reference: integer add of the selected increment, modulo element width.
  function automatic logic [DW-1:0] ref_round(input logic [DW-1:0] vec, input logic [BW-1:0] vd,
                                              input logic [BW-1:0] vd1, input logic [1:0] sew,
                                              input logic [1:0] vxrm, input logic fxp, input logic mask);
    logic [DW-1:0] res;
    int ew;
    if (!fxp || mask) return vec;
    ew  = 8 << sew;
    res = '0;
    for (int e = 0; e < DW / ew; e++) begin
      int k;
      int unsigned r;
      logic [63:0] m, x;
      k = e << sew;
      m = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
      x = (vec >> (e * ew)) & m;
      case (vxrm)
        2'd0:    r = vd1[k];
        2'd1:    r = vd1[k] & vd[k];
        2'd2:    r = 0;
        default: r = (!vd[k] && vd1[k]) ? 1 : 0;
      endcase
      x   = (x + 64'(r)) & m;
      res = res | (x << (e * ew));
    end
    return res;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    logic pop, full;
    @(posedge clk);
    if (rst) begin
      q.delete();
      st_v  = 1'b0;
      m_err = 1'b0;
    end else begin
      pop  = (q.size() != 0) && wb_ready;
      full = (q.size() == DEPTH);
      if (pop) q.delete(0);
      if (st_v) begin
        if (full && !pop) m_err = 1'b1;
        else              q.push_back(st_b);
      end
      st_v      = in_valid;
      st_b.data = ref_round(in_vec, in_vd, in_vd1, cfg_sew, cfg_vxrm, in_fxp, in_mask);
      st_b.addr = in_addr;
      st_b.be   = in_be;
      st_b.mask = in_mask;
    end
    #1;
    chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wb_data", wb_data, q[0].data);
      chk("wb_addr", 64'(wb_addr), 64'(q[0].addr));
      chk("wb_be",   64'(wb_be),   64'(q[0].be));
      chk("wb_mask", 64'(wb_mask), 64'(q[0].mask));
    end
    chk("almost_full",  64'(almost_full),  64'(q.size() >= DEPTH - AFT));
    chk("err_overflow", 64'(err_overflow), 64'(m_err));
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] vec, input logic [AW-1:0] addr,
                       input logic [BW-1:0] be, input logic mask, input logic fxp,
                       input logic [BW-1:0] vd, input logic [BW-1:0] vd1);
    in_valid = v;  in_vec = vec;   in_addr = addr; in_be = be;
    in_mask = mask; in_fxp = fxp;  in_vd = vd;     in_vd1 = vd1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_beat();
    drive(1'b1, {$urandom, $urandom}, $urandom, BW'($urandom), 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [7:0] mode_exp [4];
    mode_exp[0] = 8'h04; mode_exp[1] = 8'h04; mode_exp[2] = 8'h03; mode_exp[3] = 8'h03;
    st_v = 1'b0; m_err = 1'b0;
    rst = 1'b1; cfg_sew = 2'd0; cfg_vxrm = 2'd0; wb_ready = 1'b1;
    idle();
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_data", wb_data, 64'd0);
    chk("rst_addr", 64'(wb_addr), 64'd0);
    chk("rst_be",   64'(wb_be),   64'd0);
    chk("rst_mask", 64'(wb_mask), 64'd0);

    // Rounding modes, rounding case: byte0 = 0x03, vd = vd1 = 1.
    for (int m = 0; m < 4; m++) begin
      cfg_vxrm = 2'(m);
      drive(1'b1, 64'h03, 32'h100, 8'hFF, 1'b0, 1'b1, 8'h01, 8'h01);
      cycle();
      idle();
      cycle();
      chk("rnd_case_byte0", 64'(wb_data[7:0]), 64'(mode_exp[m]));
      cycle();
    end

    // rne / rod distinction: byte0 = 0x02, vd = 0, vd1 = 1.
    cfg_vxrm = 2'd1;
    drive(1'b1, 64'h02, 32'h104, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h01);
    cycle(); idle(); cycle();
    chk("rne_byte0", 64'(wb_data[7:0]), 64'h02);
    cfg_vxrm = 2'd3;
    drive(1'b1, 64'h02, 32'h108, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h01);
    cycle(); idle(); cycle();
    chk("rod_byte0", 64'(wb_data[7:0]), 64'h03);

    // No carry across a 16-bit element boundary.
    cfg_sew = 2'd1; cfg_vxrm = 2'd0;
    drive(1'b1, 64'h0000_0000_0001_FFFF, 32'h10C, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h01);
    cycle(); idle(); cycle();
    chk("no_xcarry", 64'(wb_data[31:0]), 64'h0001_0000);

    // Pass-through, with explicit 2-cycle latency.
    cfg_sew = 2'd0;
    drive(1'b1, 64'hFFFF_00FF_1234_ABCD, 32'h110, 8'h5A, 1'b0, 1'b0, 8'hFF, 8'hFF);
    cycle(); idle();
    chk("pt_lat_n1", 64'(wb_valid), 64'd0);
    cycle();
    chk("pt_lat_n2", 64'(wb_valid), 64'd1);
    chk("pt_fxp0", wb_data, 64'hFFFF_00FF_1234_ABCD);
    drive(1'b1, 64'h80FF_7F01_FFFF_FFFF, 32'h114, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF);
    cycle(); idle(); cycle();
    chk("pt_mask1", wb_data, 64'h80FF_7F01_FFFF_FFFF);
    cycle();

    // Backpressure: 4 beats fill the FIFO, a 5th overflows, then drain.
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_beat();
      cycle();
    end
    idle();
    cycle(); cycle();
    chk("bp_full_af",  64'(almost_full),  64'd1);
    chk("bp_overflow", 64'(err_overflow), 64'd1);
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Full with simultaneous push and pop, then mid-stream reset.
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_beat();
      cycle();
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_beat();
      cycle();
      chk("full_pp_count", 64'(q.size()), 64'(DEPTH));
    end
    chk("full_pp_noerr", 64'(err_overflow), 64'd0);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 64'(wb_valid),     64'd0);
    chk("mid_rst_af",    64'(almost_full),  64'd0);
    chk("mid_rst_err",   64'(err_overflow), 64'd0);
    rst = 1'b0;
    idle();
    cycle(); cycle();

    // Randomized traffic honouring the issue throttle.
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        cfg_sew  = 2'($urandom_range(0, 3));
        cfg_vxrm = 2'($urandom_range(0, 3));
      end
      wb_ready = ($urandom_range(0, 3) != 0);
      if (!almost_full && ($urandom_range(0, 2) != 0))
        drive(1'b1, {$urandom, $urandom}, $urandom, BW'($urandom), ($urandom_range(0, 7) == 0),
              1'($urandom), BW'($urandom), BW'($urandom));
      else
        idle();
      cycle();
    end
    idle();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
